// File: rtl/display_value_ctrl.sv
// display_value_ctrl
//   Front end for a 4-digit 7-segment scan driver. A 14-bit binary value is
//   accepted over a load/ready handshake and converted to four BCD digits by a
//   sequential double-dabble (one step per clock). The committed digits are then
//   blanked, given a decimal point, saturated on overflow, and optionally blinked.
//   A free-running prescaler produces the scan driver's clock.
//
// Ports
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   val       binary value to display (14 bits)
//   dp_pos    decimal point position: 0 none, 1..4 = D1..D4, 5..7 none
//   blank_lz  1 = suppress leading zeros
//   blink     1 = blink the whole display
//   load      request, accepted when load & ready
//   ready     high while idle and able to accept a load
//   decs      digit codes D4..D1 in [15:12]..[3:0]; 4'hf = digit off
//   points    decimal point per digit, bit k = D(k+1)
//   scan_clk  clock for the scan driver, f_clk / (2*SCAN_DIV)
//   ovf       last committed value exceeded 9999
module display_value_ctrl #(
    parameter int SCAN_DIV  = 2500,
    parameter int BLINK_DIV = 1000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [13:0] val,
    input  logic [2:0]  dp_pos,
    input  logic        blank_lz,
    input  logic        blink,
    input  logic        load,
    output logic        ready,
    output logic [15:0] decs,
    output logic [3:0]  points,
    output logic        scan_clk,
    output logic        ovf
);

    localparam int PW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state_reg, state_next;

    logic [13:0] shift_reg;
    logic [15:0] bcd_reg;
    logic [3:0]  step_reg;
    logic [2:0]  dp_reg;
    logic        blz_reg;
    logic        ovf_pend_reg;

    logic [15:0] decs_sh_reg;
    logic [3:0]  points_sh_reg;
    logic        ovf_reg;

    logic [PW-1:0] presc_reg;
    logic          scan_clk_reg;
    logic [BW-1:0] blink_cnt_reg;
    logic          phase_reg;      // 1 = hidden half of the blink period

    logic [15:0] bcd_adj;
    logic [15:0] digits;
    logic [15:0] decs_new;
    logic [3:0]  points_new;
    logic [2:0]  keep_lim;
    logic        presc_wrap;
    logic        scan_rise;

    // ------------------------------------------------------------------
    // Scan clock prescaler and blink timing
    // ------------------------------------------------------------------
    assign presc_wrap = (presc_reg == PW'(SCAN_DIV - 1));
    // scan_clk goes 0->1 on this edge
    assign scan_rise  = presc_wrap & ~scan_clk_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg    <= '0;
            scan_clk_reg <= 1'b0;
        end else if (presc_wrap) begin
            presc_reg    <= '0;
            scan_clk_reg <= ~scan_clk_reg;
        end else begin
            presc_reg    <= presc_reg + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (!blink) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (scan_rise) begin
            if (blink_cnt_reg == BW'(BLINK_DIV - 1)) begin
                blink_cnt_reg <= '0;
                phase_reg     <= ~phase_reg;
            end else begin
                blink_cnt_reg <= blink_cnt_reg + BW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (load) state_next = CONV;
            CONV:    if (step_reg == 4'd13) state_next = COMMIT;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
    // Only values <= 9999 matter; overflowing values are replaced at commit.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5)
                                      ? bcd_reg[4*gi +: 4] + 4'd3
                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg     <= '0;
            bcd_reg       <= '0;
            step_reg      <= '0;
            dp_reg        <= '0;
            blz_reg       <= 1'b0;
            ovf_pend_reg  <= 1'b0;
            decs_sh_reg   <= 16'hffff;
            points_sh_reg <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shift_reg    <= val;
                        dp_reg       <= dp_pos;
                        blz_reg      <= blank_lz;
                        ovf_pend_reg <= (val > 14'd9999);
                        bcd_reg      <= '0;
                        step_reg     <= '0;
                    end
                end
                CONV: begin
                    bcd_reg   <= {bcd_adj[14:0], shift_reg[13]};
                    shift_reg <= {shift_reg[12:0], 1'b0};
                    step_reg  <= step_reg + 4'd1;
                end
                COMMIT: begin
                    decs_sh_reg   <= decs_new;
                    points_sh_reg <= points_new;
                    ovf_reg       <= ovf_pend_reg;
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Commit formatting: saturation, leading-zero blanking, point
    // ------------------------------------------------------------------
    assign digits = ovf_pend_reg ? 16'h9999 : bcd_reg;

    // Lowest digit index that may be blanked is above this one: D1 always
    // stays, and so does the digit with the point and everything below it.
    assign keep_lim = (dp_reg >= 3'd1 && dp_reg <= 3'd4) ? dp_reg : 3'd1;

    always_comb begin
        logic leading;
        decs_new = digits;
        leading  = blz_reg;
        for (int j = 3; j >= 1; j--) begin
            if (leading && (digits[4*j +: 4] == 4'd0) && (j >= int'(keep_lim))) begin
                decs_new[4*j +: 4] = 4'hf;
            end else begin
                leading = 1'b0;
            end
        end
    end

    always_comb begin
        points_new = 4'b0000;
        case (dp_reg)
            3'd1:    points_new = 4'b0001;
            3'd2:    points_new = 4'b0010;
            3'd3:    points_new = 4'b0100;
            3'd4:    points_new = 4'b1000;
            default: points_new = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign ready    = (state_reg == IDLE);
    assign scan_clk = scan_clk_reg;
    assign ovf      = ovf_reg;
    assign decs     = (blink & phase_reg) ? 16'hffff : decs_sh_reg;
    assign points   = (blink & phase_reg) ? 4'b0000  : points_sh_reg;

endmodule

// File: tb/tb_display_value_ctrl.sv
module tb_display_value_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [13:0] val;
    logic [2:0]  dp_pos;
    logic        blank_lz;
    logic        blink;
    logic        load;
    logic        ready;
    logic [15:0] decs;
    logic [3:0]  points;
    logic        scan_clk;
    logic        ovf;

    always #5 clk = ~clk;

    display_value_ctrl #(.SCAN_DIV(4), .BLINK_DIV(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .val      (val),
        .dp_pos   (dp_pos),
        .blank_lz (blank_lz),
        .blink    (blink),
        .load     (load),
        .ready    (ready),
        .decs     (decs),
        .points   (points),
        .scan_clk (scan_clk),
        .ovf      (ovf)
    );

    typedef struct {
        logic [15:0] decs;
        logic [3:0]  pts;
        logic        ovf;
        int          v;
        int          dp;
        bit          blz;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endfunction

    // Reference: decimal digits by division, then blanking rules on the digit list.
    function automatic exp_t model(int v, int dp, bit blz);
        exp_t e;
        int   s, lim;
        int   d[4];
        bit   lead;
        s    = (v > 9999) ? 9999 : v;
        d[0] = s % 10;
        d[1] = (s / 10) % 10;
        d[2] = (s / 100) % 10;
        d[3] = (s / 1000) % 10;
        lim  = (dp >= 1 && dp <= 4) ? dp : 1;
        lead = blz;
        for (int k = 4; k >= 2; k--) begin
            if (lead && d[k-1] == 0 && k > lim) d[k-1] = 15;
            else lead = 0;
        end
        e.decs = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
        e.pts  = (dp >= 1 && dp <= 4) ? 4'(1 << (dp - 1)) : 4'b0000;
        e.ovf  = (v > 9999);
        e.v    = v;
        e.dp   = dp;
        e.blz  = blz;
        return e;
    endfunction

    // Monitor: a completed conversion shows up as ready rising again.
    bit prev_ready = 1'b1;
    int low_cnt    = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_ready = 1'b1;
            low_cnt    = 0;
        end else begin
            if (!ready) begin
                low_cnt++;
            end else if (!prev_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_commit: got decs=%h want none", decs);
                end else begin
                    e = exp_q.pop_front();
                    $display("commit val=%0d dp=%0d blz=%0d decs=%h points=%b ovf=%0d busy=%0d",
                             e.v, e.dp, e.blz, decs, points, ovf, low_cnt);
                    chk("decs", 32'(decs), 32'(e.decs));
                    chk("points", 32'(points), 32'(e.pts));
                    chk("ovf", 32'(ovf), 32'(e.ovf));
                    chk("latency", 32'(low_cnt), 32'd15);
                end
                low_cnt = 0;
            end
            prev_ready = ready;
        end
    end

    task automatic wait_ready(string name);
        int budget = 0;
        while (!ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!ready) chk(name, 32'(ready), 32'd1);
    endtask

    task automatic do_load(int v, int dp, bit blz, bit noisy);
        wait_ready("ready_timeout_pre");
        val      = 14'(v);
        dp_pos   = 3'(dp);
        blank_lz = blz;
        load     = 1'b1;
        exp_q.push_back(model(v, dp, blz));
        @(negedge clk);
        load = 1'b0;
        if (noisy) begin
            for (int i = 0; i < 6; i++) begin
                val      = 14'($urandom);
                dp_pos   = 3'($urandom);
                blank_lz = 1'($urandom);
                load     = 1'b1;
                @(negedge clk);
                load = 1'b0;
                @(negedge clk);
            end
        end
        wait_ready("ready_timeout_post");
        @(negedge clk);
    endtask

    initial begin
        int  rises, hi_len, per_len, budget;
        bit  prev_sc, hidden;

        rst_n = 1'b0; val = '0; dp_pos = '0; blank_lz = 1'b0; blink = 1'b0; load = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_decs", 32'(decs), 32'hffff);
        chk("rst_points", 32'(points), 32'd0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_scan_clk", 32'(scan_clk), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // directed values
        do_load(1234, 0, 1'b1, 1'b0);
        do_load(5, 3, 1'b1, 1'b0);
        do_load(5, 0, 1'b0, 1'b0);
        do_load(0, 0, 1'b1, 1'b0);
        do_load(12000, 0, 1'b1, 1'b0);
        do_load(7, 0, 1'b1, 1'b0);
        do_load(9999, 4, 1'b1, 1'b0);
        do_load(16383, 2, 1'b0, 1'b0);
        do_load(40, 2, 1'b1, 1'b0);
        // loads during conversion must be ignored
        do_load(4321, 4, 1'b1, 1'b1);
        do_load(80, 0, 1'b1, 1'b1);

        // randomized
        for (int n = 0; n < 24; n++) begin
            do_load(int'($urandom_range(0, 16383)), int'($urandom_range(0, 7)),
                    1'($urandom), 1'($urandom_range(0, 3) == 0));
        end
        for (int n = 0; n < 8; n++) begin
            do_load(int'($urandom_range(0, 120)), int'($urandom_range(0, 7)), 1'b1, 1'b0);
        end

        // reset in the middle of a conversion
        wait_ready("ready_timeout_rst");
        val = 14'd2222; dp_pos = 3'd0; blank_lz = 1'b0; load = 1'b1;
        exp_q.push_back(model(2222, 0, 1'b0));
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        $display("midreset decs=%h ready=%0d", decs, ready);
        chk("midrst_decs", 32'(decs), 32'hffff);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_points", 32'(points), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_load(1234, 2, 1'b0, 1'b0);

        // scan clock period: 4 clocks high, 8 clocks per period
        for (int r = 0; r < 2; r++) begin
            budget = 0;
            prev_sc = scan_clk;
            while (!(scan_clk && !prev_sc) && budget < 50) begin
                prev_sc = scan_clk; @(negedge clk); budget++;
            end
            hi_len = 0; per_len = 0; budget = 0;
            prev_sc = scan_clk;
            do begin
                @(negedge clk);
                per_len++;
                if (prev_sc) hi_len++;
                budget++;
                if (scan_clk && !prev_sc) break;
                prev_sc = scan_clk;
            end while (budget < 50);
            $display("scan_clk period=%0d high=%0d", per_len, hi_len);
            chk("scan_period", 32'(per_len), 32'd8);
            chk("scan_high", 32'(hi_len), 32'd4);
        end

        // blink: phase flips every 2 scan_clk rises (16 clocks), first half visible
        blink   = 1'b1;
        rises   = 0;
        prev_sc = scan_clk;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (scan_clk && !prev_sc) rises++;
            prev_sc = scan_clk;
            hidden = ((rises / 2) % 2) == 1;
            chk("blink_decs", 32'(decs), hidden ? 32'hffff : 32'h1234);
            chk("blink_points", 32'(points), hidden ? 32'd0 : 32'b0010);
        end
        $display("blink rises=%0d", rises);
        budget = 0;
        while (!hidden && budget < 40) begin
            @(negedge clk);
            if (scan_clk && !prev_sc) rises++;
            prev_sc = scan_clk;
            hidden = ((rises / 2) % 2) == 1;
            budget++;
        end
        chk("hidden_reached", 32'(hidden), 32'd1);
        chk("hidden_decs", 32'(decs), 32'hffff);
        blink = 1'b0;
        #1;
        $display("unblink decs=%h points=%b", decs, points);
        chk("unblink_decs", 32'(decs), 32'h1234);
        chk("unblink_points", 32'(points), 32'b0010);

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
